sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single external memory port (27-bit byte address, 8-bit data) between three requesters.
- Requesters, highest priority first:
  - Download loader (DL): ROM/config images into RAM/SRAM.
  - CPU slot mapper (CPU): translated mapper address, rnw, ram_cs/sram_cs.
  - Floppy/SD sector buffer DMA (DMA).
- Sequences one access at a time with a 4-state machine. Enforces read-only regions, a DMA anti-starvation guard and a memory-timeout watchdog.

Parameters:
- STARVE_LIMIT, 4, consecutive grants lost by a pending DMA before DMA is promoted above CPU (range 1..15).
- TIMEOUT, 255, cycles waited for mem_ready before the access is aborted with error (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dl_req  in  1  DL request, level, held until dl_ack
- dl_addr  in  27  DL byte address
- dl_din  in  8  DL write data; DL is always a write
- dl_ack  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU request, level
- cpu_addr  in  27  mapper address
- cpu_rnw  in  1  1=read, 0=write
- cpu_cs  in  1  ram_cs|sram_cs; 0 = unmapped
- cpu_ro  in  1  target is read-only
- cpu_din  in  8  CPU write data
- cpu_ack  out  1  completion pulse
- dma_req  in  1  DMA request, level
- dma_addr  in  27  DMA address
- dma_rnw  in  1  1=read, 0=write
- dma_din  in  8  DMA write data
- dma_ack  out  1  completion pulse
- rd_data  out  8  read data, valid in the ack cycle
- err  out  1  timeout flag, valid in the ack cycle
- mem_req  out  1  one-cycle access strobe
- mem_addr  out  27  registered address
- mem_we  out  1  registered write enable
- mem_dout  out  8  registered write data
- mem_din  in  8  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion from memory

Behaviour:
- Reset values:
  - All outputs 0 (rd_data 0x00, mem_addr 0).
  - State IDLE; starve counter 0; timeout counter 0.
  - A reset asserted mid-access drops mem_req immediately. A mem_ready arriving after reset is ignored.
- State IDLE:
  - Evaluate requests every cycle.
  - Priority: DL > DMA-if-starved > CPU > DMA. DMA is starved when starve counter = STARVE_LIMIT.
  - On a winner, register addr/we/data and go to ISSUE.
- CPU short-cuts (no memory cycle):
  - cpu_cs=0: go straight to DONE. cpu_ack with rd_data=0xFF on read; write discarded.
  - cpu_rnw=0 with cpu_ro=1: same path, write discarded, no mem_req.
- State ISSUE: mem_req=1 for exactly one cycle, then WAIT. mem_ready is accepted already in ISSUE.
- State WAIT:
  - On mem_ready: latch mem_din into rd_data if read; go to DONE.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT: go to DONE with err=1 and rd_data=0xFF.
  - mem_ready later than the timeout is ignored.
- State DONE:
  - Exactly one of dl_ack/cpu_ack/dma_ack is 1 for one cycle. rd_data and err hold until the next DONE.
  - Requests are not sampled in DONE; the requester must drop req on the cycle after ack or issue a new access.
  - Next state IDLE.
- Latency: request seen at cycle N → mem_req at N+1. With mem_ready at cycle M, ack is at M+1.
  - Minimum memory access: 3 cycles (mem_ready in ISSUE).
  - Short-cut access: ack at N+1.
- Starve counter:
  - +1, saturating at STARVE_LIMIT, on each grant to DL or CPU while dma_req=1.
  - Cleared on a DMA grant.
- Simultaneous requests: resolved only in IDLE by the priority above. Losers keep req asserted.
- err clears to 0 at the next DONE unless that access also times out.

Test Plan:
- Single CPU read 0x0012345, mem_ready 2 cycles after mem_req, mem_din=0xA5 → mem_req at N+1 with mem_we=0; cpu_ack at M+1 with rd_data=0xA5, err=0.
- dl_req, cpu_req, dma_req all raised same cycle → grant order DL, CPU, DMA. Each ack is a single-cycle pulse; mem_addr matches the respective requester.
- cpu_req held continuously with DMA pending, STARVE_LIMIT=4 → 4 CPU grants, then DMA granted 5th; counter returns 0.
- CPU write, cpu_ro=1, addr 0x0004000 → no mem_req; cpu_ack at N+1. Same with cpu_cs=0 read → rd_data=0xFF.
- DMA read, mem_ready never asserted, TIMEOUT=255 → dma_ack after 255 WAIT cycles with err=1, rd_data=0xFF. A late mem_ready is ignored and the next access completes normally.
- reset pulsed during WAIT of a DL write → all outputs 0, state IDLE. The subsequent mem_ready produces no ack; the re-raised dl_req is serviced fresh.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle between the memory-port arbiter and its three requesters plus the
// external memory port.
//
// Handshake: each requester raises *_req as a level and holds its address,
// data and direction steady until the matching *_ack pulses for exactly one
// cycle. On the memory side, mem_req is a one-cycle strobe that launches an
// access, and mem_ready is a one-cycle completion that returns mem_din for reads.
interface sdram_port_arbiter_if;
    logic        dl_req;
    logic [26:0] dl_addr;
    logic [7:0]  dl_din;
    logic        dl_ack;

    logic        cpu_req;
    logic [26:0] cpu_addr;
    logic        cpu_rnw;
    logic        cpu_cs;
    logic        cpu_ro;
    logic [7:0]  cpu_din;
    logic        cpu_ack;

    logic        dma_req;
    logic [26:0] dma_addr;
    logic        dma_rnw;
    logic [7:0]  dma_din;
    logic        dma_ack;

    logic [7:0]  rd_data;
    logic        err;

    logic        mem_req;
    logic [26:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ready;

    // Observability: sequencer state and the DMA starvation counter.
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_starve;

    modport slave (
        input  dl_req, dl_addr, dl_din,
        input  cpu_req, cpu_addr, cpu_rnw, cpu_cs, cpu_ro, cpu_din,
        input  dma_req, dma_addr, dma_rnw, dma_din,
        input  mem_din, mem_ready,
        output dl_ack, cpu_ack, dma_ack, rd_data, err,
        output mem_req, mem_addr, mem_we, mem_dout,
        output dbg_state, dbg_starve
    );

    modport master (
        output dl_req, dl_addr, dl_din,
        output cpu_req, cpu_addr, cpu_rnw, cpu_cs, cpu_ro, cpu_din,
        output dma_req, dma_addr, dma_rnw, dma_din,
        output mem_din, mem_ready,
        input  dl_ack, cpu_ack, dma_ack, rd_data, err,
        input  mem_req, mem_addr, mem_we, mem_dout,
        input  dbg_state, dbg_starve
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter for the single external memory port. The download loader
// always wins. The CPU normally beats DMA, but a DMA that has lost
// STARVE_LIMIT grants in a row is promoted above the CPU. Accesses run one at a
// time through IDLE -> ISSUE -> WAIT -> DONE. Unmapped CPU accesses and CPU
// writes to read-only targets complete without a memory cycle. A watchdog
// aborts an access whose mem_ready never arrives.
module sdram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic                 clk,
    input logic                 reset,
    sdram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DL   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_MAX    = 8'(TIMEOUT);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic [26:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_dout_q, mem_dout_d;

    logic        dma_starved;
    logic [3:0]  starve_inc;
    logic        cpu_shortcut;
    logic        grant_dl;
    logic        grant_dma;
    logic        grant_cpu;

    assign dma_starved  = (starve_q >= STARVE_MAX);
    assign starve_inc   = dma_starved ? starve_q : starve_q + 4'd1;
    // Unmapped accesses and writes to read-only targets never reach memory.
    assign cpu_shortcut = !bus.cpu_cs || (!bus.cpu_rnw && bus.cpu_ro);

    assign grant_dl  = bus.dl_req;
    assign grant_dma = !bus.dl_req && bus.dma_req && (dma_starved || !bus.cpu_req);
    assign grant_cpu = !bus.dl_req && bus.cpu_req && !grant_dma;

    // Next-state logic: arbitration in IDLE, the memory handshake with its
    // watchdog in ISSUE/WAIT, and the completion pulse in DONE.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        tmo_d      = '0;
        rnw_d      = rnw_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        mem_dout_d = mem_dout_q;

        case (state_q)
            S_IDLE: begin
                if (grant_dl) begin
                    owner_d    = OWN_DL;
                    rnw_d      = 1'b0;
                    mem_addr_d = bus.dl_addr;
                    mem_we_d   = 1'b1;
                    mem_dout_d = bus.dl_din;
                    state_d    = S_ISSUE;
                    if (bus.dma_req) starve_d = starve_inc;
                end else if (grant_dma) begin
                    owner_d    = OWN_DMA;
                    rnw_d      = bus.dma_rnw;
                    mem_addr_d = bus.dma_addr;
                    mem_we_d   = !bus.dma_rnw;
                    mem_dout_d = bus.dma_din;
                    state_d    = S_ISSUE;
                    starve_d   = '0;
                end else if (grant_cpu) begin
                    owner_d = OWN_CPU;
                    rnw_d   = bus.cpu_rnw;
                    if (bus.dma_req) starve_d = starve_inc;
                    if (cpu_shortcut) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                        if (bus.cpu_rnw) rd_data_d = 8'hFF;
                    end else begin
                        mem_addr_d = bus.cpu_addr;
                        mem_we_d   = !bus.cpu_rnw;
                        mem_dout_d = bus.cpu_din;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                if (bus.mem_ready) begin
                    if (rnw_q) rd_data_d = bus.mem_din;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (state_q == S_ISSUE) begin
                    state_d = S_WAIT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TMO_MAX) begin
                        err_d     = 1'b1;
                        rd_data_d = 8'hFF;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            tmo_q      <= '0;
            rnw_q      <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            rnw_q      <= rnw_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    assign bus.mem_req    = (state_q == S_ISSUE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.dl_ack     = (state_q == S_DONE) && (owner_q == OWN_DL);
    assign bus.cpu_ack    = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign bus.dma_ack    = (state_q == S_DONE) && (owner_q == OWN_DMA);
    assign bus.rd_data    = rd_data_q;
    assign bus.err        = err_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_starve = starve_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a memory responder task, a scoreboard of
// expected memory strobes and completions, and one task per scenario.
module tb_sdram_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [11:0] exp_q[$];      // {dl_ack, cpu_ack, dma_ack, rd_data, err}
    logic [35:0] exp_mem_q[$];  // {mem_we, mem_addr, mem_dout}
    logic [7:0]  model_rd;

    typedef struct packed {
        logic        got_req;
        int          req_lat;
        logic        req_2nd;
        logic [26:0] addr;
        logic        we;
        logic [7:0]  dout;
        logic        got_ack;
        int          ack_lat;
        int          ack_from_req;
        logic [2:0]  acks;
        logic [7:0]  rd;
        logic        err;
        logic [2:0]  acks_after;
        logic [1:0]  state_after;
        logic [3:0]  starve_after;
    } obs_t;

    sdram_port_arbiter_if bus();

    sdram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.dl_req = 1'b0;  bus.dl_addr = '0;  bus.dl_din = '0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_rnw = 1'b1;
        bus.cpu_cs = 1'b1;  bus.cpu_ro = 1'b0; bus.cpu_din = '0;
        bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_rnw = 1'b1; bus.dma_din = '0;
        bus.mem_din = '0;   bus.mem_ready = 1'b0;
    endtask

    // Memory responder: waits (bounded) for a strobe or a completion, answers
    // mem_ready ready_delay cycles after the strobe (negative = never), and
    // records what it saw. Drops the acknowledged request unless hold is set.
    task automatic serve(input int ready_delay, input logic [7:0] din, input bit hold,
                         output obs_t o);
        int k;
        o = '0;
        k = -1;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (k == 0) o.req_2nd = bus.mem_req;
            if (bus.dl_ack || bus.cpu_ack || bus.dma_ack) begin
                o.got_ack      = 1'b1;
                o.ack_lat      = t;
                o.ack_from_req = (k >= 0) ? k + 1 : 0;
                o.acks         = {bus.dl_ack, bus.cpu_ack, bus.dma_ack};
                o.rd           = bus.rd_data;
                o.err          = bus.err;
                break;
            end
            if (bus.mem_req && !o.got_req) begin
                o.got_req = 1'b1;
                o.req_lat = t;
                o.addr    = bus.mem_addr;
                o.we      = bus.mem_we;
                o.dout    = bus.mem_dout;
                k = 0;
            end else if (k >= 0) begin
                k++;
            end
            if (k >= 0 && k == ready_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_din   = din;
            end
        end
        if (o.got_ack) begin
            if (!hold) begin
                if (bus.dl_ack)  bus.dl_req  = 1'b0;
                if (bus.cpu_ack) bus.cpu_req = 1'b0;
                if (bus.dma_ack) bus.dma_req = 1'b0;
            end
            @(negedge clk);
            o.acks_after   = {bus.dl_ack, bus.cpu_ack, bus.dma_ack};
            o.state_after  = bus.dbg_state;
            o.starve_after = bus.dbg_starve;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_rd = 8'h00;
        total++;
        if ({bus.dl_ack, bus.cpu_ack, bus.dma_ack, bus.mem_req, bus.mem_we, bus.err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.dl_ack, bus.cpu_ack, bus.dma_ack, bus.mem_req, bus.mem_we, bus.err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_dout, bus.rd_data} !== 43'd0) begin
            bad++;
            $display("FAIL reset_bus: addr=%h dout=%h rd=%h want all 0", bus.mem_addr, bus.mem_dout, bus.rd_data);
        end
        total++;
        if ({bus.dbg_state, bus.dbg_starve} !== 6'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d starve=%0d want 0/0", bus.dbg_state, bus.dbg_starve);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.dbg_state !== 2'd0 || bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: state=%0d mem_req=%b want 0/0", bus.dbg_state, bus.mem_req);
        end
    endtask

    task automatic test_cpu_read();
        obs_t o;
        logic [35:0] m;
        logic [11:0] e;
        bus.cpu_req = 1'b1; bus.cpu_addr = 27'h0012345; bus.cpu_rnw = 1'b1;
        bus.cpu_cs = 1'b1;  bus.cpu_ro = 1'b0;          bus.cpu_din = 8'h99;
        exp_mem_q.push_back({1'b0, 27'h0012345, 8'h00});
        model_rd = 8'hA5;
        exp_q.push_back({3'b010, model_rd, 1'b0});
        serve(2, 8'hA5, 1'b0, o);
        total++;
        if (!o.got_req || o.req_lat != 1) begin
            bad++; $display("FAIL cpu_rd_req_lat: got req=%b lat=%0d want 1/1", o.got_req, o.req_lat);
        end
        m = (exp_mem_q.size() > 0) ? exp_mem_q.pop_front() : '1;
        total++;
        if ({o.we, o.addr} !== m[35:8]) begin
            bad++; $display("FAIL cpu_rd_mem: got we=%b addr=%h want %b/%h", o.we, o.addr, m[35], m[34:8]);
        end
        total++;
        if (o.req_2nd !== 1'b0) begin
            bad++; $display("FAIL cpu_rd_req_pulse: mem_req second cycle=%b want 0", o.req_2nd);
        end
        total++;
        if (!o.got_ack || o.ack_from_req != 3) begin
            bad++; $display("FAIL cpu_rd_ack_lat: got ack=%b lat=%0d want 1/3", o.got_ack, o.ack_from_req);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if ({o.acks, o.rd, o.err} !== e) begin
            bad++; $display("FAIL cpu_rd_ack: got %h want %h", {o.acks, o.rd, o.err}, e);
        end
        total++;
        if (o.acks_after !== 3'b000) begin
            bad++; $display("FAIL cpu_rd_ack_pulse: got %b want 000", o.acks_after);
        end
    endtask

    task automatic test_priority();
        obs_t o;
        logic [35:0] m;
        logic [11:0] e;
        int          delays[3] = '{0, 1, 0};
        logic [7:0]  dins[3]   = '{8'hEE, 8'h5C, 8'hEE};
        logic [3:0]  starve[3] = '{4'd1, 4'd2, 4'd0};
        bus.dl_req  = 1'b1; bus.dl_addr  = 27'h1ABCDEF; bus.dl_din = 8'h11;
        bus.cpu_req = 1'b1; bus.cpu_addr = 27'h0000100; bus.cpu_rnw = 1'b1;
        bus.cpu_cs  = 1'b1; bus.cpu_ro   = 1'b0;
        bus.dma_req = 1'b1; bus.dma_addr = 27'h7FFFFFF; bus.dma_rnw = 1'b0; bus.dma_din = 8'h3C;
        exp_mem_q.push_back({1'b1, 27'h1ABCDEF, 8'h11});
        exp_mem_q.push_back({1'b0, 27'h0000100, 8'h00});
        exp_mem_q.push_back({1'b1, 27'h7FFFFFF, 8'h3C});
        exp_q.push_back({3'b100, model_rd, 1'b0});
        model_rd = 8'h5C;
        exp_q.push_back({3'b010, model_rd, 1'b0});
        exp_q.push_back({3'b001, model_rd, 1'b0});
        for (int i = 0; i < 3; i++) begin
            serve(delays[i], dins[i], 1'b0, o);
            m = (exp_mem_q.size() > 0) ? exp_mem_q.pop_front() : '1;
            total++;
            if (!o.got_req || o.req_lat != 1 ||
                {o.we, o.addr, (o.we ? o.dout : 8'h00)} !== {m[35:8], (m[35] ? m[7:0] : 8'h00)}) begin
                bad++;
                $display("FAIL prio_mem[%0d]: got req=%b lat=%0d we=%b addr=%h dout=%h want %h",
                         i, o.got_req, o.req_lat, o.we, o.addr, o.dout, m);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            total++;
            if (!o.got_ack || {o.acks, o.rd, o.err} !== e || o.acks_after !== 3'b000) begin
                bad++;
                $display("FAIL prio_ack[%0d]: got %h after=%b want %h after=000",
                         i, {o.acks, o.rd, o.err}, o.acks_after, e);
            end
            total++;
            if (o.starve_after !== starve[i]) begin
                bad++; $display("FAIL prio_starve[%0d]: got %0d want %0d", i, o.starve_after, starve[i]);
            end
        end
    endtask

    task automatic test_starvation();
        obs_t o;
        logic [35:0] m;
        logic [11:0] e;
        logic [7:0]  d;
        bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_cs = 1'b1; bus.cpu_ro = 1'b0;
        bus.dma_req = 1'b1; bus.dma_rnw = 1'b1; bus.dma_addr = 27'h0000ABC;
        for (int i = 0; i <= STARVE_LIMIT; i++) begin
            d = 8'h30 + 8'(i);
            bus.cpu_addr = 27'h0002000 + 27'(i);
            if (i < STARVE_LIMIT) begin
                exp_mem_q.push_back({1'b0, bus.cpu_addr, 8'h00});
                exp_q.push_back({3'b010, d, 1'b0});
            end else begin
                exp_mem_q.push_back({1'b0, 27'h0000ABC, 8'h00});
                exp_q.push_back({3'b001, d, 1'b0});
            end
            model_rd = d;
            serve(0, d, (i < STARVE_LIMIT), o);
            m = (exp_mem_q.size() > 0) ? exp_mem_q.pop_front() : '1;
            total++;
            if (!o.got_req || {o.we, o.addr} !== m[35:8]) begin
                bad++; $display("FAIL starve_mem[%0d]: got req=%b we=%b addr=%h want %h", i, o.got_req, o.we, o.addr, m[35:8]);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            total++;
            if (!o.got_ack || {o.acks, o.rd, o.err} !== e) begin
                bad++; $display("FAIL starve_ack[%0d]: got %h want %h", i, {o.acks, o.rd, o.err}, e);
            end
            total++;
            if (o.starve_after !== ((i < STARVE_LIMIT) ? 4'(i + 1) : 4'd0)) begin
                bad++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, o.starve_after,
                                (i < STARVE_LIMIT) ? i + 1 : 0);
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_shortcuts();
        obs_t o;
        logic [11:0] e;
        // Write to a read-only target: no memory cycle, rd_data untouched.
        bus.cpu_req = 1'b1; bus.cpu_addr = 27'h0004000; bus.cpu_rnw = 1'b0;
        bus.cpu_cs  = 1'b1; bus.cpu_ro   = 1'b1;        bus.cpu_din = 8'h77;
        exp_q.push_back({3'b010, model_rd, 1'b0});
        serve(-1, 8'h00, 1'b0, o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (o.got_req || !o.got_ack || o.ack_lat != 1) begin
            bad++; $display("FAIL ro_write_path: got req=%b ack=%b lat=%0d want 0/1/1", o.got_req, o.got_ack, o.ack_lat);
        end
        total++;
        if ({o.acks, o.rd, o.err} !== e || o.acks_after !== 3'b000) begin
            bad++; $display("FAIL ro_write_ack: got %h after=%b want %h", {o.acks, o.rd, o.err}, o.acks_after, e);
        end
        // Unmapped read returns 0xFF without touching memory.
        bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_cs = 1'b0; bus.cpu_ro = 1'b0;
        model_rd = 8'hFF;
        exp_q.push_back({3'b010, model_rd, 1'b0});
        serve(-1, 8'h00, 1'b0, o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (o.got_req || !o.got_ack || o.ack_lat != 1) begin
            bad++; $display("FAIL unmapped_path: got req=%b ack=%b lat=%0d want 0/1/1", o.got_req, o.got_ack, o.ack_lat);
        end
        total++;
        if ({o.acks, o.rd, o.err} !== e) begin
            bad++; $display("FAIL unmapped_ack: got %h want %h", {o.acks, o.rd, o.err}, e);
        end
        bus.cpu_cs = 1'b1;
    endtask

    task automatic test_timeout();
        obs_t o;
        logic [11:0] e;
        bus.dma_req = 1'b1; bus.dma_addr = 27'h0000200; bus.dma_rnw = 1'b1;
        model_rd = 8'hFF;
        exp_q.push_back({3'b001, model_rd, 1'b1});
        serve(-1, 8'h00, 1'b0, o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (!o.got_req || !o.got_ack || o.ack_from_req != TIMEOUT + 1) begin
            bad++; $display("FAIL timeout_lat: got req=%b ack=%b lat=%0d want 1/1/%0d",
                            o.got_req, o.got_ack, o.ack_from_req, TIMEOUT + 1);
        end
        total++;
        if ({o.acks, o.rd, o.err} !== e) begin
            bad++; $display("FAIL timeout_ack: got %h want %h", {o.acks, o.rd, o.err}, e);
        end
        // Late completion from memory while idle must be ignored.
        bus.mem_ready = 1'b1; bus.mem_din = 8'h12;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        total++;
        if ({bus.dl_ack, bus.cpu_ack, bus.dma_ack} !== 3'b000 || bus.dbg_state !== 2'd0 || bus.rd_data !== 8'hFF) begin
            bad++; $display("FAIL late_ready: acks=%b state=%0d rd=%h want 000/0/ff",
                            {bus.dl_ack, bus.cpu_ack, bus.dma_ack}, bus.dbg_state, bus.rd_data);
        end
        bus.dma_req = 1'b1; bus.dma_addr = 27'h0000204; bus.dma_rnw = 1'b1;
        model_rd = 8'h77;
        exp_q.push_back({3'b001, model_rd, 1'b0});
        serve(2, 8'h77, 1'b0, o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (!o.got_ack || {o.acks, o.rd, o.err} !== e) begin
            bad++; $display("FAIL after_timeout_ack: got %h want %h", {o.acks, o.rd, o.err}, e);
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        logic [35:0] m;
        logic [11:0] e;
        bus.dl_req = 1'b1; bus.dl_addr = 27'h0ABCDE0; bus.dl_din = 8'h42;
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b1) begin
            bad++; $display("FAIL mid_issue: mem_req=%b want 1", bus.mem_req);
        end
        @(negedge clk);
        total++;
        if (bus.dbg_state !== 2'd2) begin
            bad++; $display("FAIL mid_wait: state=%0d want 2", bus.dbg_state);
        end
        reset = 1'b1;
        bus.dl_req = 1'b0;
        @(negedge clk);
        model_rd = 8'h00;
        total++;
        if ({bus.dl_ack, bus.cpu_ack, bus.dma_ack, bus.mem_req, bus.mem_we, bus.err,
             bus.mem_addr, bus.mem_dout, bus.rd_data, bus.dbg_state} !== 51'd0) begin
            bad++; $display("FAIL mid_reset: req=%b we=%b addr=%h dout=%h rd=%h state=%0d want all 0",
                            bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_dout, bus.rd_data, bus.dbg_state);
        end
        reset = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_din = 8'h99;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        total++;
        if ({bus.dl_ack, bus.cpu_ack, bus.dma_ack} !== 3'b000 || bus.dbg_state !== 2'd0) begin
            bad++; $display("FAIL mid_late_ready: acks=%b state=%0d want 000/0",
                            {bus.dl_ack, bus.cpu_ack, bus.dma_ack}, bus.dbg_state);
        end
        bus.dl_req = 1'b1; bus.dl_addr = 27'h0ABCDE1; bus.dl_din = 8'h43;
        exp_mem_q.push_back({1'b1, 27'h0ABCDE1, 8'h43});
        exp_q.push_back({3'b100, model_rd, 1'b0});
        serve(1, 8'hEE, 1'b0, o);
        m = (exp_mem_q.size() > 0) ? exp_mem_q.pop_front() : '1;
        total++;
        if (!o.got_req || o.req_lat != 1 || {o.we, o.addr, o.dout} !== m) begin
            bad++; $display("FAIL mid_fresh_mem: got req=%b lat=%0d %h want %h",
                            o.got_req, o.req_lat, {o.we, o.addr, o.dout}, m);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (!o.got_ack || {o.acks, o.rd, o.err} !== e || o.ack_from_req != 2) begin
            bad++; $display("FAIL mid_fresh_ack: got %h lat=%0d want %h lat=2",
                            {o.acks, o.rd, o.err}, o.ack_from_req, e);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_priority();
        test_starvation();
        test_shortcuts();
        test_timeout();
        test_reset_mid_access();
        total++;
        if (exp_q.size() != 0 || exp_mem_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: ack left=%0d mem left=%0d want 0/0", exp_q.size(), exp_mem_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
